// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// PcSequencer (module pc_sequencer)
// Program-counter stage of the RISC datapath. Holds the PC in a bank of
// rising-edge D flip-flops and picks the next PC each cycle: increment,
// branch target, stall hold or halt hold. A small BOOT/RUN/HALT machine
// sequences start-up after reset and halt/resume.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   stall_i      hold the PC this cycle (pipeline back-pressure)
//   br_en_i      load br_addr_i as the next PC
//   br_addr_i    branch/jump target
//   halt_req_i   enter HALT at the next edge
//   resume_i     leave HALT at the next edge
//   pc_o         current program counter (registered)
//   pc_plus1_o   pc_o + 1 modulo 2^WIDTH (combinational link source)
//   valid_o      fetch at pc_o is live (state RUN)
//   halted_o     sequencer is in HALT
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned     WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             br_en_i,
    input  logic [WIDTH-1:0] br_addr_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus1_o,
    output logic             valid_o,
    output logic             halted_o
);

    // Code 2'b11 is deliberately unused; it is steered back to BOOT.
    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;

    // Increment wraps naturally at the register width; the carry is dropped.
    assign pc_plus1_o = pc_q + 1'b1;

    // State and PC registers. Reset acts immediately, regardless of the clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-PC selection. In RUN the halt request outranks a
    // branch, and a branch outranks a stall. HALT only leaves on a resume
    // that is not accompanied by a fresh halt request.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_req_i) begin
                    state_d = HALT;
                end else if (br_en_i) begin
                    pc_d = br_addr_i;
                end else if (!stall_i) begin
                    pc_d = pc_plus1_o;
                end
            end
            HALT: begin
                if (resume_i && !halt_req_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc_o     = pc_q;
    assign valid_o  = (state_q == RUN);
    assign halted_o = (state_q == HALT);

endmodule
